// File: rtl/opsel_pkg.sv
// Shared encodings and default widths for the operand-select stage and its
// immediate extender.
package opsel_pkg;

    localparam int OPSEL_WIDTH = 32;
    localparam int OPSEL_IMM_W = 16;

    typedef enum logic [1:0] {
        EXT_ZERO = 2'b00,
        EXT_SIGN = 2'b01,
        EXT_BR   = 2'b10,
        EXT_LUI  = 2'b11
    } ext_mode_e;

endpackage

// File: rtl/operand_sel_stage_imm_extender.sv
// Purely combinational immediate extender: zero/sign extension, branch offset
// (sign-extend then x4) and LUI placement.
module imm_extender
    import opsel_pkg::*;
#(
    parameter int WIDTH = OPSEL_WIDTH,
    parameter int IMM_W = OPSEL_IMM_W
) (
    input  logic [IMM_W-1:0] imm_i,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] ext_o
);

    logic [WIDTH-1:0] sext_s;

    // Extension mode select.
    always_comb begin
        sext_s = {{(WIDTH-IMM_W){imm_i[IMM_W-1]}}, imm_i};
        case (mode_i)
            EXT_ZERO: ext_o = {{(WIDTH-IMM_W){1'b0}}, imm_i};
            EXT_SIGN: ext_o = sext_s;
            EXT_BR:   ext_o = {sext_s[WIDTH-3:0], 2'b00};
            EXT_LUI:  ext_o = {imm_i, {(WIDTH-IMM_W){1'b0}}};
            default:  ext_o = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/operand_sel_stage.sv
// Registered operand-select stage: source/immediate mux feeding a DEPTH-entry
// FIFO with valid/ready on both sides. Optional macro SEL_CHECK_EN traps sel > N_IN.
module operand_sel_stage
    import opsel_pkg::*;
#(
    parameter int WIDTH = OPSEL_WIDTH,
    parameter int N_IN  = 4,
    parameter int IMM_W = OPSEL_IMM_W,
    parameter int DEPTH = 2,
    localparam int SEL_W = $clog2(N_IN + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_IN*WIDTH-1:0] data_in,
    input  logic [IMM_W-1:0]      imm,
    input  logic [1:0]            ext_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  sel_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [SEL_W-1:0] IMM_SEL  = SEL_W'(N_IN);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] buf_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sel_err_q, sel_err_d;
    logic [WIDTH-1:0] imm_ext_s, src_val_s, sel_val_s;
    logic             sel_bad_s, push_s, pop_s;

    imm_extender #(.WIDTH(WIDTH), .IMM_W(IMM_W)) u_ext (
        .imm_i  (imm),
        .mode_i (ext_mode),
        .ext_o  (imm_ext_s)
    );

    // One-hot AND-OR selection of the data_in slot addressed by sel.
    always_comb begin
        src_val_s = {WIDTH{1'b0}};
        for (int k = 0; k < N_IN; k++) begin
            src_val_s = src_val_s | (data_in[k*WIDTH +: WIDTH] & {WIDTH{sel == SEL_W'(k)}});
        end
    end

    // Source versus immediate, with out-of-range select handling.
    always_comb begin
        sel_bad_s = 1'b0;
        if (sel < IMM_SEL) begin
            sel_val_s = src_val_s;
        end else if (sel == IMM_SEL) begin
            sel_val_s = imm_ext_s;
        end else begin
`ifdef SEL_CHECK_EN
            sel_val_s = {WIDTH{1'b0}};
            sel_bad_s = 1'b1;
`else
            sel_val_s = imm_ext_s;
`endif
        end
    end

    assign in_ready  = (count_q < FULL_CNT);
    assign out_valid = (count_q != {CNT_W{1'b0}});
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;
    assign out_data  = out_valid ? buf_q[rd_ptr_q] : {WIDTH{1'b0}};
    assign sel_err   = sel_err_q;

    // Pointer, occupancy and sticky error next-state; flush wins over push/pop.
    always_comb begin
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        sel_err_d = sel_err_q;
        if (flush) begin
            count_d  = {CNT_W{1'b0}};
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            if (push_s && sel_bad_s) begin
                sel_err_d = 1'b1;
            end else begin
                sel_err_d = sel_err_q;
            end
        end
    end

    // State registers and buffer storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= {CNT_W{1'b0}};
            wr_ptr_q  <= {PTR_W{1'b0}};
            rd_ptr_q  <= {PTR_W{1'b0}};
            sel_err_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            sel_err_q <= sel_err_d;
            if (push_s && !flush) begin
                buf_q[wr_ptr_q] <= sel_val_s;
            end
        end
    end

endmodule

// File: tb/tb_operand_sel_stage.sv
// Self-checking bench for operand_sel_stage against a queue-based reference
// model; expectations follow SEL_CHECK_EN when it is defined.
module tb_operand_sel_stage;

    localparam int W = 32;
    localparam int N = 4;
    localparam int IW = 16;
    localparam int D = 2;
    localparam int SW = $clog2(N + 1);
`ifdef SEL_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic          in_ready, out_valid, sel_err;
    logic [SW-1:0] sel;
    logic [N*W-1:0] data_in;
    logic [IW-1:0] imm;
    logic [1:0]    ext_mode;
    logic [W-1:0]  out_data;

    int n_vec = 0;
    int n_bad = 0;
    logic [W-1:0] q [$];
    bit err_m = 1'b0;

    always #5 clk = ~clk;

    operand_sel_stage #(.WIDTH(W), .N_IN(N), .IMM_W(IW), .DEPTH(D)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .data_in(data_in), .imm(imm),
        .ext_mode(ext_mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .sel_err(sel_err)
    );

    function automatic logic [W-1:0] ref_val(int s, logic [N*W-1:0] d, logic [IW-1:0] im, int m);
        longint sx;
        if (s < N) return d[s*W +: W];
        if (s > N && CHK) return '0;
        sx = (im >= 16'h8000) ? longint'(im) - 65536 : longint'(im);
        case (m)
            0:       return W'(longint'(im));
            1:       return W'(sx);
            2:       return W'(sx * 4);
            default: return W'(longint'(im) * 65536);
        endcase
    endfunction

    task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".in_ready"},  W'(in_ready),  W'(q.size() < D));
        chk({tag, ".out_valid"}, W'(out_valid), W'(q.size() != 0));
        chk({tag, ".out_data"},  out_data, (q.size() != 0) ? q[0] : '0);
        chk({tag, ".sel_err"},   W'(sel_err),   W'(err_m));
    endtask

    // One clock: model decides push/pop from pre-edge state, DUT is checked after the edge.
    task automatic tick(string tag);
        bit push_m, pop_m;
        logic [W-1:0] v;
        push_m = in_valid && (q.size() < D);
        pop_m  = (q.size() != 0) && out_ready;
        v = ref_val(int'(sel), data_in, imm, int'(ext_mode));
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (pop_m) void'(q.pop_front());
            if (push_m) begin
                q.push_back(v);
                if (int'(sel) > N && CHK) err_m = 1'b1;
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic drive(bit v, int s, logic [IW-1:0] im, int m, bit ordy);
        in_valid = v; sel = SW'(s); imm = im; ext_mode = 2'(m); out_ready = ordy;
    endtask

    logic [W-1:0] ext_exp [4] = '{32'h00008004, 32'hFFFF8004, 32'hFFFE0010, 32'h80040000};
    int ext_order [4] = '{1, 2, 3, 0};

    initial begin
        reset = 1'b1; flush = 1'b0; data_in = '0;
        drive(1'b0, 0, '0, 0, 1'b0);
        #12;
        check_all("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic select of slot 2.
        data_in[2*W +: W] = 32'hDEAD_BEEF;
        drive(1'b1, 2, '0, 0, 1'b1);
        tick("slot2");
        chk("slot2.const", out_data, 32'hDEADBEEF);
        drive(1'b0, 2, '0, 0, 1'b1);
        tick("slot2.drain");

        // Each extension mode through the immediate select.
        foreach (ext_order[i]) begin
            drive(1'b1, N, 16'h8004, ext_order[i], 1'b1);
            tick("ext");
            chk($sformatf("ext.mode%0d", ext_order[i]), out_data, ext_exp[ext_order[i]]);
        end
        drive(1'b0, 0, '0, 0, 1'b1);
        tick("ext.drain");

        // Back-pressure: three requests, the third is held while full.
        for (int i = 0; i < 3; i++) begin
            data_in[0 +: W] = 32'h1000_0000 + W'(i);
            drive(1'b1, 0, '0, 0, 1'b0);
            tick("bp.fill");
        end
        chk("bp.full_in_ready", W'(in_ready), '0);
        drive(1'b1, 0, '0, 0, 1'b1);
        tick("bp.full_pop");
        chk("bp.first_out", out_data, 32'h1000_0001);
        chk("bp.ready_after_pop", W'(in_ready), 32'd1);
        tick("bp.accept_held");
        drive(1'b0, 0, '0, 0, 1'b1);
        tick("bp.drain1");
        tick("bp.drain2");

        // Flush with a full buffer and a push offered.
        data_in[W +: W] = 32'hAAAA_5555;
        drive(1'b1, 1, '0, 0, 1'b0);
        tick("fl.fill1");
        tick("fl.fill2");
        data_in[W +: W] = 32'hBAD0_BAD0;
        flush = 1'b1;
        tick("fl.flush");
        flush = 1'b0;
        chk("fl.out_data", out_data, '0);
        chk("fl.in_ready", W'(in_ready), 32'd1);
        drive(1'b0, 1, '0, 0, 1'b1);
        tick("fl.after");

        // Out-of-range select, then flush must leave the sticky flag alone.
        drive(1'b1, 7, 16'h1234, 1, 1'b0);
        tick("oor.push");
        chk("oor.value", out_data, CHK ? 32'h0 : 32'h00001234);
        chk("oor.sel_err", W'(sel_err), W'(CHK));
        drive(1'b0, 0, '0, 0, 1'b0);
        flush = 1'b1;
        tick("oor.flush");
        flush = 1'b0;
        chk("oor.sel_err_kept", W'(sel_err), W'(CHK));

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) data_in[k*W +: W] = $urandom;
            drive(1'($urandom_range(0, 3) != 0), $urandom_range(0, 7), 16'($urandom),
                  $urandom_range(0, 3), 1'($urandom_range(0, 2) != 0));
            flush = ($urandom_range(0, 19) == 0);
            tick("rand");
        end
        flush = 1'b0;

        // Asynchronous reset in the middle of a cycle.
        drive(1'b1, 3, '0, 0, 1'b0);
        tick("ar.fill");
        #2;
        reset = 1'b1;
        #1;
        q.delete();
        err_m = 1'b0;
        check_all("ar.async");
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b0, 0, '0, 0, 1'b1);
        tick("ar.after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
